// File: rtl/am_demodulator.sv
// Envelope demodulator: per lrclk frame, rectify, one-pole leaky integrate,
// remove DC offset and apply a signed Q1.(BITSIZE-1) gain.
module am_demodulator #(
  parameter int BITSIZE = 16,
  parameter int K       = 4
) (
  input  logic                      bclk,
  input  logic                      reset,
  input  logic                      lrclk,
  input  logic signed [BITSIZE-1:0] in,
  input  logic signed [BITSIZE-1:0] offset,
  input  logic signed [BITSIZE-1:0] gain,
  output logic signed [BITSIZE-1:0] out,
  output logic                      out_valid,
  output logic                      overrun
);

  localparam int W  = BITSIZE;
  localparam int PW = 2 * W + 1;

  localparam logic signed [PW-1:0] SAT_HI = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECT   = 3'd1,
    S_FILT   = 3'd2,
    S_SCALE  = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  function automatic logic signed [W-1:0] saturate(input logic signed [PW-1:0] v);
    if (v > SAT_HI) begin
      saturate = {1'b0, {(W - 1){1'b1}}};
    end else if (v < SAT_LO) begin
      saturate = {1'b1, {(W - 1){1'b0}}};
    end else begin
      saturate = v[W-1:0];
    end
  endfunction

  state_t                state_q;
  logic                  lrclk_q;
  logic signed [W-1:0]   x_q;
  logic signed [W-1:0]   off_q;
  logic signed [W-1:0]   gain_q;
  logic        [W-2:0]   r_q;
  logic        [W-2:0]   env_q;
  logic signed [W-1:0]   scaled_q;
  logic signed [W-1:0]   out_q;
  logic                  out_valid_q;
  logic                  overrun_q;

  logic                  edge_s;
  logic        [W-1:0]   abs_s;
  logic        [W-2:0]   r_d;
  logic signed [W:0]     diff_s;
  logic signed [W:0]     env_sum_s;
  logic        [W-2:0]   env_d;
  logic signed [W:0]     d_s;
  logic signed [PW-1:0]  p_s;
  logic signed [W-1:0]   scaled_d;

  // Datapath for each processing stage; the FSM picks which result to keep.
  always_comb begin
    edge_s    = lrclk & ~lrclk_q;
    abs_s     = x_q[W-1] ? (~x_q + W'(1)) : x_q;
    if (abs_s[W-1]) begin
      r_d = {(W - 1){1'b1}};
    end else begin
      r_d = abs_s[W-2:0];
    end
    diff_s    = $signed({2'b00, r_q}) - $signed({2'b00, env_q});
    env_sum_s = $signed({2'b00, env_q}) + (diff_s >>> K);
    // Mathematically the sum never leaves 0..2^(W-1)-1; clamp anyway.
    if (env_sum_s[W]) begin
      env_d = {(W - 1){1'b0}};
    end else if (env_sum_s[W-1]) begin
      env_d = {(W - 1){1'b1}};
    end else begin
      env_d = env_sum_s[W-2:0];
    end
    d_s       = $signed({2'b00, env_q}) - $signed({off_q[W-1], off_q});
    p_s       = PW'(d_s) * PW'(gain_q);
    scaled_d  = saturate(p_s >>> (W - 1));
  end

  // Frame FSM with all state and registered outputs.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lrclk_q     <= 1'b0;
      x_q         <= {W{1'b0}};
      off_q       <= {W{1'b0}};
      gain_q      <= {W{1'b0}};
      r_q         <= {(W - 1){1'b0}};
      env_q       <= {(W - 1){1'b0}};
      scaled_q    <= {W{1'b0}};
      out_q       <= {W{1'b0}};
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      lrclk_q     <= lrclk;
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (edge_s) begin
            x_q     <= in;
            off_q   <= offset;
            gain_q  <= gain;
            state_q <= S_RECT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RECT: begin
          r_q     <= r_d;
          state_q <= S_FILT;
        end
        S_FILT: begin
          env_q   <= env_d;
          state_q <= S_SCALE;
        end
        S_SCALE: begin
          scaled_q <= scaled_d;
          state_q  <= S_OUTPUT;
        end
        S_OUTPUT: begin
          out_q       <= scaled_q;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      if (edge_s && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_am_demodulator.sv
// Directed bench for am_demodulator (BITSIZE=16, K=4, 32-bclk frames).
module tb_am_demodulator;

  logic               bclk = 1'b0;
  logic               reset = 1'b1;
  logic               lrclk = 1'b0;
  logic signed [15:0] in_s = 16'sd0;
  logic signed [15:0] off_s = 16'sd0;
  logic signed [15:0] gain_s = 16'sd0;
  logic signed [15:0] out_s;
  logic               out_valid;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  am_demodulator #(.BITSIZE(16), .K(4)) dut (
    .bclk      (bclk),
    .reset     (reset),
    .lrclk     (lrclk),
    .in        (in_s),
    .offset    (off_s),
    .gain      (gain_s),
    .out       (out_s),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 bclk = ~bclk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge bclk);
    reset = 1'b1;
    lrclk = 1'b0;
    repeat (2) @(negedge bclk);
    reset = 1'b0;
  endtask

  // One 32-bclk frame; inputs are scrambled right after the latch cycle.
  task automatic frame(input int in_v, input int off_v, input int gain_v, output int out_v);
    @(negedge bclk);
    in_s   = 16'(in_v);
    off_s  = 16'(off_v);
    gain_s = 16'(gain_v);
    lrclk  = 1'b1;
    @(negedge bclk);
    in_s   = 16'($urandom);
    off_s  = 16'($urandom);
    gain_s = 16'($urandom);
    repeat (3) @(negedge bclk);
    check("valid_before_lat4", int'(out_valid), 0);
    @(negedge bclk);
    check("valid_at_lat4", int'(out_valid), 1);
    out_v = int'(out_s);
    repeat (10) @(negedge bclk);
    lrclk = 1'b0;
    repeat (16) @(negedge bclk);
  endtask

  // Two frame edges 'gap' cycles apart, both with in=16000, gain=+1.
  task automatic edges(input int gap, input int exp_nv, input int exp_ovr, input int exp_out);
    int nv;
    do_reset();
    in_s   = 16'sd16000;
    off_s  = 16'sd0;
    gain_s = 16'sh7FFF;
    @(negedge bclk);
    lrclk = 1'b1;
    nv    = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge bclk);
      if (out_valid) nv++;
      lrclk = (i == gap);
    end
    check($sformatf("gap%0d_valids", gap), nv, exp_nv);
    check($sformatf("gap%0d_overrun", gap), int'(overrun), exp_ovr);
    check($sformatf("gap%0d_out", gap), int'(out_s), exp_out);
  endtask

  initial begin
    int o;
    int prev;
    int mono;
    int nv;

    // Reset held with toggling inputs.
    for (int i = 0; i < 10; i++) begin
      @(negedge bclk);
      lrclk  = 1'($urandom);
      in_s   = 16'($urandom);
      off_s  = 16'($urandom);
      gain_s = 16'($urandom);
    end
    check("rst_out", int'(out_s), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    @(negedge bclk);
    lrclk = 1'b0;
    @(negedge bclk);
    reset = 1'b0;
    frame(0, 0, 32'h7FFF, o);
    check("first_zero_out", o, 0);

    do_reset();
    frame(16000, 0, 32'h7FFF, o);
    check("single_out", o, 999);
    check("single_env", int'(dut.env_q), 1000);

    do_reset();
    frame(-32768, 0, 32'h7FFF, o);
    check("rect_clamp_out", o, 2046);
    check("rect_clamp_env", int'(dut.env_q), 2047);

    do_reset();
    frame(16000, -32768, 32'h7FFF, o);
    check("sat_pos_out", o, 32767);
    frame(0, -32767, -32768, o);
    check("sat_neg_env", int'(dut.env_q), 937);
    check("sat_neg_out", o, -32768);

    do_reset();
    prev = -32768;
    mono = 1;
    for (int f = 1; f <= 200; f++) begin
      frame(16000, 0, 32'h7FFF, o);
      if (o < prev) mono = 0;
      prev = o;
      if (f == 180) check("conv_env_f180", int'(dut.env_q), 15985);
    end
    check("conv_monotonic", mono, 1);
    check("conv_env_final", int'(dut.env_q), 15985);
    check("conv_out_final", o, 15984);

    edges(5, 2, 0, 1936);
    edges(4, 1, 1, 999);
    edges(3, 1, 1, 999);
    repeat (40) @(negedge bclk);
    check("overrun_sticky", int'(overrun), 1);

    // Reset asserted two cycles into a frame aborts it.
    in_s   = 16'sd16000;
    off_s  = 16'sd0;
    gain_s = 16'sh7FFF;
    @(negedge bclk);
    lrclk = 1'b1;
    @(negedge bclk);
    lrclk = 1'b0;
    @(negedge bclk);
    reset = 1'b1;
    nv    = 0;
    #1;
    check("midrst_out_async", int'(out_s), 0);
    check("midrst_overrun_async", int'(overrun), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge bclk);
      if (out_valid) nv++;
      if (i == 9) reset = 1'b0;
    end
    check("midrst_valids", nv, 0);
    check("midrst_out", int'(out_s), 0);
    check("midrst_overrun", int'(overrun), 0);
    frame(16000, 0, 32'h7FFF, o);
    check("after_rst_fresh", o, 999);

    // lrclk held high yields a single frame.
    do_reset();
    in_s   = 16'sd16000;
    off_s  = 16'sd0;
    gain_s = 16'sh7FFF;
    @(negedge bclk);
    lrclk = 1'b1;
    nv    = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge bclk);
      if (out_valid) nv++;
    end
    lrclk = 1'b0;
    check("held_high_valids", nv, 1);
    check("held_high_overrun", int'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/am_demodulator.md
# am_demodulator

Envelope (AM) demodulator, the receive-side counterpart of the modulator's `((a*in2)+b)*in1` AM product. Once per audio frame it captures a sample, full-wave rectifies it, and low-pass filters it with a one-pole leaky integrator to recover the envelope. It then removes a DC offset and applies a signed gain, producing one demodulated sample per frame. It runs in the bclk domain alongside the other audio cores, with lrclk used only as a frame strobe.

## Interface
- `BITSIZE`, 16, sample, offset and gain width (signed two's complement).
- `K`, 4, filter shift; smoothing coefficient is 2^-K, legal range 1..BITSIZE-2.
- `bclk` input 1: the sole clock; all state changes on posedge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `lrclk` input 1: frame strobe, synchronous to bclk, sampled on posedge bclk; it is never used as a clock.
- `in` input BITSIZE: signed AM input sample.
- `offset` input BITSIZE: signed DC value subtracted from the envelope.
- `gain` input BITSIZE: signed Q1.(BITSIZE-1) output gain; 0x7FFF ≈ +1.0.
- `out` output BITSIZE: signed demodulated sample, held between updates.
- `out_valid` output 1: one-cycle pulse when `out` updates.
- `overrun` output 1: sticky; set when a frame strobe arrives while busy.

## Operation
- Reset values: `out`=0, `out_valid`=0, `overrun`=0, envelope register `env`=0, state IDLE, `lrclk_q`=0.
- `lrclk_q` is a registered copy of `lrclk`. A frame edge is `lrclk & ~lrclk_q` at a posedge.
- FSM states: IDLE → RECT → FILT → SCALE → OUTPUT → IDLE, advancing one state per bclk. Only IDLE waits.
- IDLE:
  - On a frame edge, latch `in` into `x`, latch `offset` and `gain`, and go to RECT.
  - If there is no edge, stay in IDLE.
- RECT: `r = |x|`, unsigned BITSIZE-1 magnitude. `x` = -2^(BITSIZE-1) saturates to 2^(BITSIZE-1)-1.
- FILT:
  - Compute `diff = r - env` as a signed BITSIZE+1 value.
  - Update `env <= env + (diff >>> K)`, using an arithmetic shift that floors toward -inf.
  - `env` always stays within 0..2^(BITSIZE-1)-1.
  - Consequence: for constant `r`, `env` converges to the point where |r-env| < 2^K and then stops moving. It does not reach `r` exactly.
- SCALE:
  - Compute `d = env - offset` as signed BITSIZE+1.
  - Compute `p = d * gain` as signed 2*BITSIZE+1.
  - Compute `q = p >>> (BITSIZE-1)`.
  - One signed multiplier is used, in this state only.
- OUTPUT:
  - Drive `out <= sat(q)`, clamped to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
  - Pulse `out_valid` = 1 for this cycle only.
- Overrun:
  - A frame edge seen in any state other than IDLE sets `overrun` and discards that sample.
  - The computation in progress completes unaffected.
  - `overrun` stays at 1 until reset.
- Frame edge in the OUTPUT cycle: this counts as busy, so the sample is dropped and `overrun` is set.
- Changes to `offset`, `gain` or `in` after the latch cycle have no effect on the current frame.

## Timing
- A frame edge detected at posedge N produces RECT at N+1, FILT at N+2, SCALE at N+3.
- `out`/`out_valid` are updated at posedge N+4, giving a latency of 4 bclk.
- Minimum edge spacing is 5 bclk. A 32- or 64-bclk frame leaves ample margin.
- Throughput is one output per frame.
- Reset asserted mid-computation returns everything to reset values immediately (asynchronously).
  - No `out_valid` is generated for the aborted frame.
  - After deassertion, the first frame edge starts a fresh computation from `env`=0.
- An `lrclk` held high produces only one edge. Processing is triggered only by a low-to-high transition.

## Test plan
All scenarios use BITSIZE=16, K=4 and 32-bclk frames.
- Reset: assert `reset` with random inputs toggling → `out`=0, `out_valid`=0, `overrun`=0. The first frame after release with `in`=0, `offset`=0 gives `out`=0.
- Single frame: `in`=16000, `offset`=0, `gain`=0x7FFF → `env`=1000, `out`=999 with `out_valid` high exactly 4 bclk after the edge.
- Rectify and clamp: `in`=-32768, `offset`=0, `gain`=0x7FFF on the first frame → `env`=2047, `out`=2046.
- Saturation:
  - `offset`=-32768, `in`=16000, `gain`=0x7FFF on the first frame → `out`=32767.
  - `in`=0, `offset`=-32767, `gain`=-32768 → `out`=-32768.
- Convergence: constant `in`=16000, `offset`=0, `gain`=0x7FFF for 200 frames → `env` settles at 15985 and stays there. `out` is monotonically non-decreasing and ends at 15984.
- Overrun and reset: two frame edges 3 bclk apart → one `out_valid`, `overrun`=1 until reset. Then assert `reset` at N+2 of a new frame → no `out_valid`, and all outputs read 0.
